// File: rtl/sdram_bridge_p.sv
// Single-port bus to SDRAM bridge: open-page controller with per-bank row tracking,
// power-up init sequence and periodic auto-refresh.
module sdram_bridge_p #(
    parameter int DATA_W   = 32,
    parameter int ROW_W    = 14,
    parameter int COL_W    = 10,
    parameter int BANK_W   = 2,
    parameter int TRCD     = 2,
    parameter int TCAS     = 2,
    parameter int TRP      = 2,
    parameter int TRFC     = 6,
    parameter int REF_INT  = 780,
    parameter int INIT_CYC = 100
) (
    input  logic              in_HCLK,
    input  logic              in_HRESET,
    input  logic              in_HSEL,
    input  logic              in_HWRITE,
    input  logic [31:0]       in_HADDR,
    input  logic [DATA_W-1:0] in_HWDATA,
    output logic              out_HREADY,
    output logic [DATA_W-1:0] out_HRDATA,
    output logic              out_CS_n,
    output logic              out_RAS_n,
    output logic              out_CAS_n,
    output logic              out_WE_n,
    output logic [BANK_W-1:0] out_BA,
    output logic [ROW_W-1:0]  out_ADDR,
    output logic [DATA_W-1:0] out_DQ,
    output logic              out_DQ_OE,
    input  logic [DATA_W-1:0] in_DQ
);

    localparam int NBANK = 1 << BANK_W;
    localparam int CNT_W = 16;
    localparam int REF_W = 16;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1024);

    typedef enum logic [3:0] {
        S_INIT, S_INIT_PRE, S_INIT_REF, S_IDLE, S_PRE, S_TRP_W, S_ACT,
        S_TRCD_W, S_RD, S_CAS_W, S_WR, S_REF_PRE, S_REF, S_TRFC_W
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                init_q;
    logic                maint_q;
    logic                pend_q;
    logic [REF_W-1:0]    ref_cnt_q;
    logic                ref_wrap;

    logic [NBANK-1:0]    open_vld_q;
    logic [ROW_W-1:0]    open_row_q [NBANK];
    logic [NBANK-1:0]    bank_match;

    logic [BANK_W-1:0]   acc_bank_q;
    logic [ROW_W-1:0]    acc_row_q;
    logic [COL_W-1:0]    acc_col_q;
    logic                acc_write_q;
    logic [DATA_W-1:0]   acc_wdata_q;

    logic                hready_q;
    logic [DATA_W-1:0]   hrdata_q;
    logic [3:0]          cmd_q;
    logic [BANK_W-1:0]   ba_q;
    logic [ROW_W-1:0]    addr_q;
    logic [DATA_W-1:0]   dq_q;
    logic                dq_oe_q;

    logic [COL_W-1:0]    col_in;
    logic [BANK_W-1:0]   bank_in;
    logic [ROW_W-1:0]    row_in;
    logic                hit_in;
    logic                conflict_in;
    logic                unused_addr_w;

    assign col_in  = in_HADDR[2 +: COL_W];
    assign bank_in = in_HADDR[2 + COL_W +: BANK_W];
    assign row_in  = in_HADDR[2 + COL_W + BANK_W +: ROW_W];
    assign unused_addr_w = ^{in_HADDR[1:0], in_HADDR[31:2 + COL_W + BANK_W]};

    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank_cmp
            assign bank_match[gi] = open_vld_q[gi] && (open_row_q[gi] == row_in);
        end
    endgenerate

    assign hit_in      = bank_match[bank_in];
    assign conflict_in = open_vld_q[bank_in] && !bank_match[bank_in];

    assign ref_wrap = (ref_cnt_q == REF_W'(REF_INT - 1));

    // Free-running refresh interval timer; never paused by the FSM.
    always_ff @(posedge in_HCLK or negedge in_HRESET) begin
        if (!in_HRESET) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + 1'b1;
        end
    end

    assign out_HREADY = hready_q;
    assign out_HRDATA = hrdata_q;
    assign {out_CS_n, out_RAS_n, out_CAS_n, out_WE_n} = cmd_q;
    assign out_BA     = ba_q;
    assign out_ADDR   = addr_q;
    assign out_DQ     = dq_q;
    assign out_DQ_OE  = dq_oe_q;

    // Commands are registered together with the state they belong to, so the
    // bus sees each command in the first cycle of its state. Access-path waits
    // assume TRP and TRCD of at least 2; init and refresh waits run a full
    // TRP/TRFC after the command cycle for extra margin.
    always_ff @(posedge in_HCLK or negedge in_HRESET) begin
        if (!in_HRESET) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_q      <= 1'b1;
            maint_q     <= 1'b0;
            pend_q      <= 1'b0;
            open_vld_q  <= '0;
            for (int i = 0; i < NBANK; i++) begin
                open_row_q[i] <= '0;
            end
            acc_bank_q  <= '0;
            acc_row_q   <= '0;
            acc_col_q   <= '0;
            acc_write_q <= 1'b0;
            acc_wdata_q <= '0;
            hready_q    <= 1'b0;
            hrdata_q    <= '0;
            cmd_q       <= CMD_NOP;
            ba_q        <= '0;
            addr_q      <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            cmd_q    <= CMD_NOP;
            dq_oe_q  <= 1'b0;
            hready_q <= 1'b0;
            if (ref_wrap) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                S_INIT: begin
                    if (cnt_q == CNT_W'(INIT_CYC)) begin
                        state_q <= S_INIT_PRE;
                        cmd_q   <= CMD_PRE;
                        addr_q  <= ADDR_A10;
                        maint_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_INIT_PRE, S_REF_PRE: begin
                    state_q <= S_TRP_W;
                    cnt_q   <= CNT_W'(TRP - 1);
                end

                S_TRP_W: begin
                    if (cnt_q == '0) begin
                        if (maint_q) begin
                            state_q <= init_q ? S_INIT_REF : S_REF;
                            cmd_q   <= CMD_REF;
                            pend_q  <= ref_wrap;
                        end else begin
                            state_q                <= S_ACT;
                            cmd_q                  <= CMD_ACT;
                            ba_q                   <= acc_bank_q;
                            addr_q                 <= acc_row_q;
                            open_vld_q[acc_bank_q] <= 1'b1;
                            open_row_q[acc_bank_q] <= acc_row_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_INIT_REF, S_REF: begin
                    state_q <= S_TRFC_W;
                    cnt_q   <= CNT_W'(TRFC - 1);
                end

                S_TRFC_W: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_IDLE;
                        init_q   <= 1'b0;
                        maint_q  <= 1'b0;
                        hready_q <= !(pend_q || ref_wrap);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_IDLE: begin
                    if (pend_q) begin
                        state_q    <= S_REF_PRE;
                        cmd_q      <= CMD_PRE;
                        addr_q     <= ADDR_A10;
                        open_vld_q <= '0;
                        maint_q    <= 1'b1;
                    end else if (in_HSEL && hready_q) begin
                        acc_bank_q  <= bank_in;
                        acc_row_q   <= row_in;
                        acc_col_q   <= col_in;
                        acc_write_q <= in_HWRITE;
                        acc_wdata_q <= in_HWDATA;
                        ba_q        <= bank_in;
                        if (hit_in) begin
                            state_q <= in_HWRITE ? S_WR : S_RD;
                            cmd_q   <= in_HWRITE ? CMD_WRITE : CMD_READ;
                            addr_q  <= ROW_W'(col_in);
                            if (in_HWRITE) begin
                                dq_q    <= in_HWDATA;
                                dq_oe_q <= 1'b1;
                            end
                        end else if (conflict_in) begin
                            state_q             <= S_PRE;
                            cmd_q               <= CMD_PRE;
                            addr_q              <= '0;
                            open_vld_q[bank_in] <= 1'b0;
                        end else begin
                            state_q             <= S_ACT;
                            cmd_q               <= CMD_ACT;
                            addr_q              <= row_in;
                            open_vld_q[bank_in] <= 1'b1;
                            open_row_q[bank_in] <= row_in;
                        end
                    end else begin
                        hready_q <= !ref_wrap;
                    end
                end

                S_PRE: begin
                    state_q <= S_TRP_W;
                    cnt_q   <= CNT_W'(TRP - 2);
                end

                S_ACT: begin
                    state_q <= S_TRCD_W;
                    cnt_q   <= CNT_W'(TRCD - 2);
                end

                S_TRCD_W: begin
                    if (cnt_q == '0) begin
                        state_q <= acc_write_q ? S_WR : S_RD;
                        cmd_q   <= acc_write_q ? CMD_WRITE : CMD_READ;
                        ba_q    <= acc_bank_q;
                        addr_q  <= ROW_W'(acc_col_q);
                        if (acc_write_q) begin
                            dq_q    <= acc_wdata_q;
                            dq_oe_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_RD: begin
                    state_q <= S_CAS_W;
                    cnt_q   <= CNT_W'(TCAS - 1);
                end

                S_CAS_W: begin
                    if (cnt_q == '0) begin
                        hrdata_q <= in_DQ;
                        state_q  <= S_IDLE;
                        hready_q <= !(pend_q || ref_wrap);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_WR: begin
                    state_q  <= S_IDLE;
                    hready_q <= !(pend_q || ref_wrap);
                end

                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bridge_p.sv
// Directed bench for sdram_bridge_p: expected bus/SDRAM activity is queued per
// transaction cycle and compared as the DUT runs.
module tb_sdram_bridge_p;

    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [3:0] ACT   = 4'b0011;
    localparam logic [3:0] READ  = 4'b0101;
    localparam logic [3:0] WRITE = 4'b0100;
    localparam logic [3:0] PRE   = 4'b0010;
    localparam logic [3:0] REF   = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [13:0] addr;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic [31:0] dq_in;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        string       sig;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    sdram_bridge_p dut (
        .in_HCLK    (clk),
        .in_HRESET  (rst_n),
        .in_HSEL    (hsel),
        .in_HWRITE  (hwrite),
        .in_HADDR   (haddr),
        .in_HWDATA  (hwdata),
        .out_HREADY (hready),
        .out_HRDATA (hrdata),
        .out_CS_n   (cs_n),
        .out_RAS_n  (ras_n),
        .out_CAS_n  (cas_n),
        .out_WE_n   (we_n),
        .out_BA     (ba),
        .out_ADDR   (addr),
        .out_DQ     (dq_out),
        .out_DQ_OE  (dq_oe),
        .in_DQ      (dq_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [63:0] obs(string s);
        case (s)
            "cmd":   return 64'({cs_n, ras_n, cas_n, we_n});
            "ba":    return 64'(ba);
            "addr":  return 64'(addr);
            "oe":    return 64'(dq_oe);
            "dq":    return 64'(dq_out);
            "rdy":   return 64'(hready);
            "rdata": return 64'(hrdata);
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic expect_at(int c, string s, logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic issue(logic w, logic [31:0] a, logic [31:0] d);
        check("ready before issue", 64'(hready), 64'd1);
        hsel   = 1'b1;
        hwrite = w;
        haddr  = a;
        hwdata = d;
    endtask

    // Steps through cycles 1..nc after the current edge, driving in_DQ and
    // popping every expectation scheduled for each cycle.
    task automatic run_txn(string name, int nc, int dq_cyc, logic [31:0] dq_val);
        exp_t e;
        for (int c = 1; c <= nc; c++) begin
            @(negedge clk);
            if (c == 1) hsel = 1'b0;
            dq_in = (c == dq_cyc) ? dq_val : 32'hDEAD_BEEF;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                check($sformatf("%s c%0d %s", name, c, e.sig), obs(e.sig), e.val);
            end
        end
    endtask

    task automatic check_reset_outputs(string name);
        check({name, " cmd"},   obs("cmd"),   64'(NOP));
        check({name, " rdy"},   obs("rdy"),   64'd0);
        check({name, " rdata"}, obs("rdata"), 64'd0);
        check({name, " ba"},    obs("ba"),    64'd0);
        check({name, " addr"},  obs("addr"),  64'd0);
        check({name, " dq"},    obs("dq"),    64'd0);
        check({name, " oe"},    obs("oe"),    64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        hsel   = 1'b0;
        hwrite = 1'b0;
        haddr  = '0;
        hwdata = '0;
        dq_in  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Power-up: NOPs, PRE-all, REF, ready exactly at cycle 111.
        for (int c = 1; c <= 111; c++) begin
            expect_at(c, "cmd", (c == 101) ? PRE : (c == 104) ? REF : NOP);
            if (c == 101) expect_at(c, "addr", 64'h400);
            expect_at(c, "rdy", 64'(c == 111));
        end
        run_txn("init", 111, 0, 32'h0);
        $display("txn init: ready at cycle 111 checked");

        // Write to a closed bank.
        for (int c = 1; c <= 4; c++) begin
            expect_at(c, "cmd", (c == 1) ? ACT : (c == 3) ? WRITE : NOP);
            if (c == 1) begin expect_at(c, "ba", 64'd1); expect_at(c, "addr", 64'd0); end
            if (c == 3) begin
                expect_at(c, "oe", 64'd1);
                expect_at(c, "dq", 64'hA5A5_0001);
                expect_at(c, "addr", 64'd0);
            end
            if (c == 4) expect_at(c, "oe", 64'd0);
            expect_at(c, "rdy", 64'(c == 4));
        end
        issue(1'b1, 32'h0000_1000, 32'hA5A5_0001);
        run_txn("wr_closed", 4, 0, 32'h0);
        $display("txn wr_closed addr=00001000 data=a5a50001");

        // Read hit in the same row.
        for (int c = 1; c <= 4; c++) begin
            expect_at(c, "cmd", (c == 1) ? READ : NOP);
            if (c == 1) begin expect_at(c, "ba", 64'd1); expect_at(c, "addr", 64'd1); end
            if (c == 4) expect_at(c, "rdata", 64'h1234_5678);
            expect_at(c, "rdy", 64'(c == 4));
        end
        issue(1'b0, 32'h0000_1004, 32'h0);
        run_txn("rd_hit", 4, 3, 32'h1234_5678);
        $display("txn rd_hit addr=00001004");

        // Read with a row conflict in bank 1.
        for (int c = 1; c <= 8; c++) begin
            expect_at(c, "cmd", (c == 1) ? PRE : (c == 3) ? ACT : (c == 5) ? READ : NOP);
            if (c == 1) begin expect_at(c, "ba", 64'd1); expect_at(c, "addr", 64'd0); end
            if (c == 3) expect_at(c, "addr", 64'd1);
            if (c == 5) expect_at(c, "addr", 64'd5);
            if (c == 8) expect_at(c, "rdata", 64'hCAFE_F00D);
            expect_at(c, "rdy", 64'(c == 8));
        end
        issue(1'b0, 32'h0000_5014, 32'h0);
        run_txn("rd_conflict", 8, 7, 32'hCAFE_F00D);
        $display("txn rd_conflict addr=00005014");

        // Refresh counter wraps at edge 780, during a read accepted at edge 778.
        n = 0;
        while (cyc != 777 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach cycle 777", 64'(cyc), 64'd777);
        for (int c = 1; c <= 15; c++) begin
            expect_at(c, "cmd", (c == 1) ? READ : (c == 5) ? PRE : (c == 8) ? REF : NOP);
            if (c == 1) expect_at(c, "addr", 64'd6);
            if (c == 4) expect_at(c, "rdata", 64'h0BAD_F00D);
            if (c == 5) expect_at(c, "addr", 64'h400);
            if (c == 4 || c == 14 || c == 15) expect_at(c, "rdy", 64'(c == 15));
        end
        issue(1'b0, 32'h0000_5018, 32'h0);
        run_txn("rd_wrap", 15, 3, 32'h0BAD_F00D);
        $display("txn rd_wrap addr=00005018");

        // Refresh closed every row, so the previously open row needs an ACT.
        for (int c = 1; c <= 6; c++) begin
            expect_at(c, "cmd", (c == 1) ? ACT : (c == 3) ? READ : NOP);
            if (c == 1) begin expect_at(c, "ba", 64'd1); expect_at(c, "addr", 64'd1); end
            if (c == 3) expect_at(c, "addr", 64'd7);
            if (c == 6) expect_at(c, "rdata", 64'h600D_CAFE);
            expect_at(c, "rdy", 64'(c == 6));
        end
        issue(1'b0, 32'h0000_501C, 32'h0);
        run_txn("rd_after_ref", 6, 5, 32'h600D_CAFE);
        $display("txn rd_after_ref addr=0000501c");

        // Reset asserted while the write waits out TRCD.
        expect_at(1, "cmd", 64'(ACT));
        expect_at(1, "ba", 64'd2);
        expect_at(1, "addr", 64'd5);
        expect_at(2, "cmd", 64'(NOP));
        issue(1'b1, 32'h0001_600C, 32'h7777_8888);
        run_txn("wr_reset", 2, 0, 32'h0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid reset");
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("held reset c%0d cmd", c), obs("cmd"), 64'(NOP));
            check($sformatf("held reset c%0d oe", c), obs("oe"), 64'd0);
        end
        rst_n = 1'b1;
        n = 0;
        while (!hready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("re-init ready cycle", 64'(n), 64'd111);
        $display("txn wr_reset: reset during TRCD wait, re-init %0d cycles", n);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
